// File: rtl/calpoc_pkg.sv
// Shared key encoding for the calculator proof-of-concept: key codes,
// their width, and the press-priority picker used by the button front end.
package calpoc_pkg;

  localparam int KEY_W    = 3;
  localparam int NUM_KEYS = 6;

  localparam logic [KEY_W-1:0] KEY_DIGIT0 = 3'd0;
  localparam logic [KEY_W-1:0] KEY_DIGIT1 = 3'd1;
  localparam logic [KEY_W-1:0] KEY_OR     = 3'd2;
  localparam logic [KEY_W-1:0] KEY_XOR    = 3'd3;
  localparam logic [KEY_W-1:0] KEY_EQUALS = 3'd4;
  localparam logic [KEY_W-1:0] KEY_CLEAR  = 3'd5;

  // Press bit i carries key code i, so the highest set bit is the winner.
  function automatic logic [KEY_W-1:0] pickKey(input logic [NUM_KEYS-1:0] presses);
    logic [KEY_W-1:0] key;
    key = KEY_DIGIT0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (presses[i]) key = KEY_W'(i);
    end
    return key;
  endfunction

endpackage

// File: rtl/debounce_cell.sv
// One button channel: flop synchroniser, stability counter and a one-cycle
// press pulse on each accepted 0->1 change of the debounced level.
module debounce_cell
  import calpoc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SYNC_STAGES     = 2
) (
  input  logic Clock,
  input  logic ResetN,
  input  logic button,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [SYNC_STAGES-1:0] syncChain;
  logic [CNT_W-1:0]       count;
  logic                   stable;
  logic                   synced;

  assign synced = syncChain[SYNC_STAGES-1];

  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      syncChain <= '0;
      count     <= '0;
      stable    <= 1'b0;
      press     <= 1'b0;
    end else begin
      syncChain <= {syncChain[SYNC_STAGES-2:0], button};
      press     <= 1'b0;
      if (synced == stable) begin
        count <= '0;
      end else if (count == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        // This edge is the DEBOUNCE_CYCLES-th consecutive mismatch.
        stable <= synced;
        count  <= '0;
        press  <= synced;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Six debounced calculator buttons feeding a one-entry, priority-resolved key
// buffer. Define BUTTON_CONDITIONER_DROP_FLAG_EN to expose the DroppedKey flag.
module button_conditioner
  import calpoc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int SYNC_STAGES     = 2
) (
  input  logic             Clock,
  input  logic             ResetN,
  input  logic             ButtonFor0,
  input  logic             ButtonFor1,
  input  logic             ButtonForOR,
  input  logic             ButtonForXOR,
  input  logic             ButtonForEquals,
  input  logic             ButtonForClear,
  input  logic             KeyReady,
  output logic             KeyValid,
  output logic [KEY_W-1:0] KeyCode
`ifdef BUTTON_CONDITIONER_DROP_FLAG_EN
  ,
  output logic             DroppedKey
`endif
);

  logic [NUM_KEYS-1:0] buttons;
  logic [NUM_KEYS-1:0] presses;
  logic [KEY_W-1:0]    winner;
  logic                anyPress;
  logic                acceptNew;

  assign buttons   = {ButtonForClear, ButtonForEquals, ButtonForXOR,
                      ButtonForOR, ButtonFor1, ButtonFor0};
  assign winner    = pickKey(presses);
  assign anyPress  = |presses;
  // Clear always wins the buffer; anything else needs it free or draining now.
  assign acceptNew = (winner == KEY_CLEAR) || !KeyValid || KeyReady;

  for (genvar i = 0; i < NUM_KEYS; i++) begin : gCell
    debounce_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .SYNC_STAGES    (SYNC_STAGES)
    ) uCell (
      .Clock (Clock),
      .ResetN(ResetN),
      .button(buttons[i]),
      .press (presses[i])
    );
  end

  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      KeyValid <= 1'b0;
      KeyCode  <= KEY_DIGIT0;
    end else if (anyPress && acceptNew) begin
      KeyValid <= 1'b1;
      KeyCode  <= winner;
    end else if (KeyValid && KeyReady) begin
      KeyValid <= 1'b0;
    end
  end

`ifdef BUTTON_CONDITIONER_DROP_FLAG_EN
  always_ff @(posedge Clock) begin
    if (!ResetN) begin
      DroppedKey <= 1'b0;
    end else if (anyPress) begin
      if (winner == KEY_CLEAR) DroppedKey <= 1'b0;
      else if (!acceptNew)     DroppedKey <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner (DEBOUNCE_CYCLES=4, SYNC_STAGES=2): directed
// scenarios with literal expectations, then randomized traffic against a model.
module tb_button_conditioner;

  localparam int DC = 4;
  localparam int SS = 2;

  logic       Clock = 1'b0;
  logic       ResetN = 1'b0;
  logic       b0 = 1'b0, b1 = 1'b0, bOr = 1'b0, bXor = 1'b0, bEq = 1'b0, bClr = 1'b0;
  logic       KeyReady = 1'b0;
  logic       KeyValid;
  logic [2:0] KeyCode;
`ifdef BUTTON_CONDITIONER_DROP_FLAG_EN
  logic       DroppedKey;
`endif

  always #5 Clock = ~Clock;

  button_conditioner #(.DEBOUNCE_CYCLES(DC), .SYNC_STAGES(SS)) dut (
    .Clock          (Clock),
    .ResetN         (ResetN),
    .ButtonFor0     (b0),
    .ButtonFor1     (b1),
    .ButtonForOR    (bOr),
    .ButtonForXOR   (bXor),
    .ButtonForEquals(bEq),
    .ButtonForClear (bClr),
    .KeyReady       (KeyReady),
    .KeyValid       (KeyValid),
    .KeyCode        (KeyCode)
`ifdef BUTTON_CONDITIONER_DROP_FLAG_EN
    ,
    .DroppedKey     (DroppedKey)
`endif
  );

  int tests = 0;
  int fails = 0;

  // Model: raw history per button (bit k = raw level k edges ago), debounced
  // level, presses awaiting the buffer, and the buffer itself.
  logic [7:0] hist [6];
  logic [5:0] mStable;
  logic [5:0] pending;
  logic       mValid;
  logic [2:0] mCode;
  logic       mDrop;

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelEdge();
    logic [5:0] raw;
    logic       allDiffer;
    int         win;
    raw = {bClr, bEq, bXor, bOr, b1, b0};
    if (!ResetN) begin
      for (int b = 0; b < 6; b++) hist[b] = '0;
      mStable = '0;
      pending = '0;
      mValid  = 1'b0;
      mCode   = 3'd0;
      mDrop   = 1'b0;
    end else begin
      if (pending != 6'd0) begin
        win = 0;
        for (int i = 0; i < 6; i++) if (pending[i]) win = i;
        if (win == 5) begin
          mValid = 1'b1; mCode = 3'd5; mDrop = 1'b0;
        end else if (!mValid || KeyReady) begin
          mValid = 1'b1; mCode = 3'(win);
        end else begin
          mDrop = 1'b1;
        end
      end else if (mValid && KeyReady) begin
        mValid = 1'b0;
      end
      pending = '0;
      // A level is accepted once the synchronised input (raw delayed SS edges)
      // has disagreed with it on each of the last DC edges.
      for (int b = 0; b < 6; b++) begin
        hist[b] = {hist[b][6:0], raw[b]};
        allDiffer = 1'b1;
        for (int k = SS; k < SS + DC; k++) if (hist[b][k] == mStable[b]) allDiffer = 1'b0;
        if (allDiffer) begin
          mStable[b] = ~mStable[b];
          if (mStable[b]) pending[b] = 1'b1;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge Clock);
    modelEdge();
    #1;
    compare("KeyValid", 32'(KeyValid), 32'(mValid));
    compare("KeyCode", 32'(KeyCode), 32'(mCode));
`ifdef BUTTON_CONDITIONER_DROP_FLAG_EN
    compare("DroppedKey", 32'(DroppedKey), 32'(mDrop));
`endif
  endtask

  task automatic waitValid(input int budget, output int n);
    n = 0;
    while (KeyValid !== 1'b1 && n < budget) begin
      step();
      n++;
    end
  endtask

  task automatic releaseAll();
    b0 = 0; b1 = 0; bOr = 0; bXor = 0; bEq = 0; bClr = 0;
  endtask

  task automatic idle(input int n);
    releaseAll();
    repeat (n) step();
  endtask

  initial begin
    int n;
    int events;
    int budget;
    logic [5:0] target;

    // Held through reset, Digit1 must appear exactly 7 edges after the reset edge.
    ResetN = 0; KeyReady = 1;
    repeat (3) step();
    compare("resetValid", 32'(KeyValid), 0);
    compare("resetCode", 32'(KeyCode), 0);
    b1 = 1;
    step();
    ResetN = 1;
    waitValid(20, n);
    compare("d1Latency", n, 7);
    compare("d1Code", 32'(KeyCode), 1);
    step();
    compare("d1OneCycle", 32'(KeyValid), 0);
    events = 0;
    repeat (20) begin step(); events += int'(KeyValid); end
    b1 = 0;
    repeat (20) begin step(); events += int'(KeyValid); end
    compare("d1NoRepeat", events, 0);

    // Bouncing XOR: nothing while toggling, one event 7 edges into the hold.
    events = 0;
    for (int c = 0; c < 40; c++) begin
      bXor = ((c / 2) % 2 == 0);
      step();
      events += int'(KeyValid);
    end
    compare("xorBounce", events, 0);
    bXor = 1;
    waitValid(30, n);
    compare("xorLatency", n, 7);
    compare("xorCode", 32'(KeyCode), 3);
    events = 0;
    repeat (10) begin step(); events += int'(KeyValid); end
    compare("xorSingle", events, 0);

    // Simultaneous OR + Equals resolves to Equals alone.
    idle(12);
    bOr = 1; bEq = 1;
    waitValid(30, n);
    compare("eqLatency", n, 7);
    compare("eqCode", 32'(KeyCode), 4);
    events = 0;
    repeat (10) begin step(); events += int'(KeyValid); end
    compare("eqSingle", events, 0);

    // Held Digit0 blocks Digit1; Clear overwrites.
    idle(12);
    KeyReady = 0;
    b0 = 1;
    waitValid(30, n);
    compare("heldCode", 32'(KeyCode), 0);
    b1 = 1;
    repeat (12) step();
    compare("heldValid", 32'(KeyValid), 1);
    compare("heldAfterDrop", 32'(KeyCode), 0);
`ifdef BUTTON_CONDITIONER_DROP_FLAG_EN
    compare("dropFlagSet", 32'(DroppedKey), 1);
`endif
    bClr = 1;
    budget = 0;
    while (KeyCode !== 3'd5 && budget < 30) begin step(); budget++; end
    compare("clearCode", 32'(KeyCode), 5);
    compare("clearValid", 32'(KeyValid), 1);
`ifdef BUTTON_CONDITIONER_DROP_FLAG_EN
    compare("dropFlagClr", 32'(DroppedKey), 0);
`endif

    // Reset mid-handshake discards the held OR; Digit1 held through reset follows.
    releaseAll();
    KeyReady = 1;
    idle(12);
    KeyReady = 0;
    bOr = 1;
    waitValid(30, n);
    compare("orCode", 32'(KeyCode), 2);
    bOr = 0; b1 = 1;
    ResetN = 0;
    step();
    compare("rstValid", 32'(KeyValid), 0);
    compare("rstCode", 32'(KeyCode), 0);
    ResetN = 1;
    waitValid(30, n);
    compare("rstLatency", n, 7);
    compare("rstD1Code", 32'(KeyCode), 1);

    // Randomized traffic: slow target levels with contact noise, random
    // handshake and occasional reset, all checked every edge by step().
    target = '0;
    for (int c = 0; c < 4000; c++) begin
      for (int b = 0; b < 6; b++) if ($urandom_range(39) == 0) target[b] = ~target[b];
      b0   = target[0] ^ ($urandom_range(7) == 0);
      b1   = target[1] ^ ($urandom_range(7) == 0);
      bOr  = target[2] ^ ($urandom_range(7) == 0);
      bXor = target[3] ^ ($urandom_range(7) == 0);
      bEq  = target[4] ^ ($urandom_range(7) == 0);
      bClr = target[5] ^ ($urandom_range(7) == 0);
      KeyReady = ($urandom_range(2) != 0);
      ResetN   = ($urandom_range(399) != 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 16: consecutive stable cycles required to accept a level change (range 2..65535).
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchroniser depth per button (range 2..4).
REQ-003 SHALL have port Clock, input, 1: the single clock; all logic on the rising edge.
REQ-004 SHALL have port ResetN, input, 1: synchronous, active-low reset.
REQ-005 SHALL have ports ButtonFor0, ButtonFor1, ButtonForOR, ButtonForXOR, ButtonForEquals, ButtonForClear, input, 1 each: raw asynchronous, bouncing, active-high buttons.
REQ-006 SHALL have port KeyValid, output, 1: a key event is held on KeyCode.
REQ-007 SHALL have port KeyCode, output, 3: 0=Digit0, 1=Digit1, 2=OR, 3=XOR, 4=Equals, 5=Clear; 6 and 7 are never driven.
REQ-008 SHALL have port KeyReady, input, 1: the downstream calculator consumes the key.

Function
REQ-009 Each button SHALL pass through a SYNC_STAGES-deep flop synchroniser before any other use.
REQ-010 Debounce per button: the counter SHALL increment while synced != stable, reset to 0 while synced == stable, and flip stable on the edge where it reaches DEBOUNCE_CYCLES.
REQ-011 A press event SHALL be a 0->1 transition of a button's stable level; release (1->0) SHALL generate no event.
REQ-012 Latency from raw input held high to KeyValid high SHALL be exactly SYNC_STAGES+DEBOUNCE_CYCLES+1 clock edges.
REQ-013 A glitch shorter than DEBOUNCE_CYCLES synced cycles SHALL generate no event and SHALL reset that button's counter.
REQ-014 Simultaneous press events on one edge SHALL be resolved by priority Clear > Equals > XOR > OR > Digit1 > Digit0; lower-priority events SHALL be discarded.
REQ-015 The output SHALL be a one-entry buffer: KeyValid/KeyCode load on a winning event and SHALL stay stable until the edge where KeyValid && KeyReady.
REQ-016 On a transfer edge with a new event present, the new event SHALL load, keeping KeyValid high without a bubble.
REQ-017 A non-Clear event arriving while the buffer holds an untransferred key SHALL be dropped; the held key is unchanged.
REQ-018 A Clear event SHALL always load, overwriting any pending key.
REQ-019 KeyReady while KeyValid is low SHALL have no effect.

Reset
REQ-020 While ResetN is low at a clock edge, all synchroniser flops, stable levels and counters SHALL clear to 0, KeyValid to 0 and KeyCode to 0.
REQ-021 A button held through reset release SHALL register as a press DEBOUNCE_CYCLES+SYNC_STAGES+1 edges after release.
REQ-022 Assertion of reset mid-debounce or mid-handshake SHALL discard all in-flight state.

Configuration
REQ-023 With macro BUTTON_CONDITIONER_DROP_FLAG_EN defined, output DroppedKey (1 bit) SHALL exist; it is set on any REQ-017 drop, sticky, cleared by reset or by loading a Clear key.
REQ-024 Without BUTTON_CONDITIONER_DROP_FLAG_EN, port DroppedKey SHALL be absent and drops are silent; all other behaviour is identical.

Structure
REQ-025 KeyCode constants (KEY_DIGIT0..KEY_CLEAR) and KEY_W=3 SHALL live in shared package calpoc_pkg, also used by the calculator top.
REQ-026 Synchroniser, debounce counter and stable-edge detect SHALL form sub-module debounce_cell, instantiated six times; priority, buffer and flag logic stay in button_conditioner.

Verification (bench uses DEBOUNCE_CYCLES=4, SYNC_STAGES=2)
REQ-027 ButtonFor1 held high from edge 0, KeyReady=1 -> KeyValid=1 and KeyCode=1 for exactly one cycle after edge 7; no further event while held or on release.
REQ-028 ButtonForXOR toggled every 2 cycles for 40 cycles, then held high -> no event during toggling; exactly one KeyCode=3 event 7 edges after the final hold begins.
REQ-029 ButtonForOR and ButtonForEquals rise on the same cycle -> a single event with KeyCode=4.
REQ-030 KeyReady=0, press Digit0 then Digit1 -> KeyCode stays 0; Digit1 dropped; DroppedKey=1 when enabled; press Clear -> KeyCode=5 and DroppedKey=0.
REQ-031 KeyValid=1 with KeyCode=2 while KeyReady=0; pulse ResetN low for one edge -> KeyValid=0 and KeyCode=0; a button held through reset produces its event at 7 edges after release.
